twiddle_cmult_pipe: RTL and testbench

Parametrised, flow-controlled complex multiplier for the FFT butterfly datapath. It computes X·W or X·conj(W), selected per sample, using a 3-multiplier (Gauss) decomposition. The result is rounded and saturated back to data width. It sits between the twiddle ROM/address generator and the butterfly stage, replacing the fixed-width, free-running multiplier with a valid/ready pipeline usable for both forward FFT and inverse FFT (via conjugation).

---
 rtl/twiddle_cmult_pipe_pkg.sv | 24 ++
 rtl/cmult_round_sat.sv | 35 +++
 rtl/twiddle_cmult_pipe.sv | 155 +++++++++++++++
 tb/tb_twiddle_cmult_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_cmult_pipe_pkg.sv
// Shared constants for the twiddle complex multiplier: the rounding constant and
// the signed saturation bounds, both parametrised by width.
`ifndef FFT_DEFS_VH
`define FFT_DEFS_VH
`define FFT_ROUND_CONST(tw_w) (64'sd1 <<< ((tw_w) - 2))
`define FFT_SAT_MAX(w)        ((64'sd1 <<< ((w) - 1)) - 64'sd1)
`define FFT_SAT_MIN(w)        (-(64'sd1 <<< ((w) - 1)))
`endif

package twiddle_cmult_pipe_pkg;

    function automatic longint round_const(input int tw_w);
        return `FFT_ROUND_CONST(tw_w);
    endfunction

    function automatic longint sat_max(input int w);
        return `FFT_SAT_MAX(w);
    endfunction

    function automatic longint sat_min(input int w);
        return `FFT_SAT_MIN(w);
    endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Post-add of two full-precision partial products, round half-up back to Q0, then
// clamp (or wrap) to DATA_W. ovf reports any result outside the DATA_W range.
module cmult_round_sat
    import twiddle_cmult_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int TW_W     = 16,
    parameter int SATURATE = 1
) (
    input  logic signed [DATA_W+TW_W+2:0] m_a,
    input  logic signed [DATA_W+TW_W+2:0] m_b,
    input  logic                          sub,
    output logic signed [DATA_W-1:0]      res,
    output logic                          ovf
);

    localparam int IW = DATA_W + TW_W + 3;
    localparam logic signed [IW-1:0] RND = IW'(round_const(TW_W));
    localparam logic signed [IW-1:0] HI  = IW'(sat_max(DATA_W));
    localparam logic signed [IW-1:0] LO  = IW'(sat_min(DATA_W));

    logic signed [IW-1:0] sum;
    logic signed [IW-1:0] shifted;

    always_comb begin
        sum     = sub ? (m_a - m_b) : (m_a + m_b);
        shifted = (sum + RND) >>> (TW_W - 1);
        ovf     = (shifted > HI) || (shifted < LO);
        res     = shifted[DATA_W-1:0];
        if (SATURATE != 0 && ovf) begin
            res = (shifted > HI) ? HI[DATA_W-1:0] : LO[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/twiddle_cmult_pipe.sv
// Four-stage valid/ready complex multiplier X*W or X*conj(W) using the 3-multiplier
// Gauss form; the whole pipe freezes together when the output is stalled.
module twiddle_cmult_pipe
    import twiddle_cmult_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int TW_W     = 16,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic signed [TW_W-1:0]   tw_real,
    input  logic signed [TW_W-1:0]   tw_imag,
    input  logic                     conj,
    input  logic                     bypass,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic                     sat_flag,
    input  logic                     sat_clear
);

    localparam int IW  = DATA_W + TW_W + 3;
    localparam int MW0 = DATA_W + TW_W + 1;
    localparam int MW1 = DATA_W + TW_W + 2;

    logic adv;
    logic signed [TW_W:0] wi_ext;
    logic signed [TW_W:0] wi_eff;

    logic                     vld_p1_q, vld_p1_d, byp_p1_q, byp_p1_d;
    logic signed [DATA_W-1:0] xr_p1_q, xr_p1_d, xi_p1_q, xi_p1_d;
    logic signed [TW_W-1:0]   wr_p1_q, wr_p1_d;
    logic signed [TW_W:0]     wi_p1_q, wi_p1_d;

    logic                     vld_p2_q, vld_p2_d, byp_p2_q, byp_p2_d;
    logic signed [DATA_W-1:0] xr_p2_q, xr_p2_d, xi_p2_q, xi_p2_d;
    logic signed [TW_W-1:0]   wr_p2_q, wr_p2_d;
    logic signed [DATA_W:0]   p0_p2_q, p0_p2_d;
    logic signed [TW_W+1:0]   p1_p2_q, p1_p2_d, p2_p2_q, p2_p2_d;

    logic                     vld_p3_q, vld_p3_d, byp_p3_q, byp_p3_d;
    logic signed [DATA_W-1:0] xr_p3_q, xr_p3_d, xi_p3_q, xi_p3_d;
    logic signed [MW0-1:0]    m0_p3_q, m0_p3_d;
    logic signed [MW1-1:0]    m1_p3_q, m1_p3_d, m2_p3_q, m2_p3_d;

    logic                     out_valid_q, out_valid_d, sat_q, sat_d;
    logic signed [DATA_W-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;

    logic signed [IW-1:0]     m0_x, m1_x, m2_x;
    logic signed [DATA_W-1:0] re_res, im_res;
    logic                     re_ovf, im_ovf;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // One extra bit so that negating the most negative twiddle stays exact.
    assign wi_ext = (TW_W+1)'(tw_imag);
    assign wi_eff = conj ? -wi_ext : wi_ext;

    assign m0_x = IW'(m0_p3_q);
    assign m1_x = IW'(m1_p3_q);
    assign m2_x = IW'(m2_p3_q);

    cmult_round_sat #(.DATA_W(DATA_W), .TW_W(TW_W), .SATURATE(SATURATE)) u_re (
        .m_a(m0_x), .m_b(m2_x), .sub(1'b1), .res(re_res), .ovf(re_ovf)
    );

    cmult_round_sat #(.DATA_W(DATA_W), .TW_W(TW_W), .SATURATE(SATURATE)) u_im (
        .m_a(m0_x), .m_b(m1_x), .sub(1'b0), .res(im_res), .ovf(im_ovf)
    );

    always_comb begin
        vld_p1_d = vld_p1_q; byp_p1_d = byp_p1_q; xr_p1_d = xr_p1_q; xi_p1_d = xi_p1_q;
        wr_p1_d  = wr_p1_q;  wi_p1_d  = wi_p1_q;
        vld_p2_d = vld_p2_q; byp_p2_d = byp_p2_q; xr_p2_d = xr_p2_q; xi_p2_d = xi_p2_q;
        wr_p2_d  = wr_p2_q;  p0_p2_d  = p0_p2_q;  p1_p2_d = p1_p2_q; p2_p2_d = p2_p2_q;
        vld_p3_d = vld_p3_q; byp_p3_d = byp_p3_q; xr_p3_d = xr_p3_q; xi_p3_d = xi_p3_q;
        m0_p3_d  = m0_p3_q;  m1_p3_d  = m1_p3_q;  m2_p3_d = m2_p3_q;
        out_valid_d = out_valid_q; out_real_d = out_real_q; out_imag_d = out_imag_q;
        sat_d = sat_q & ~sat_clear;
        if (adv) begin
            // S1: capture sample and effective twiddle
            vld_p1_d = in_valid;
            byp_p1_d = bypass;
            xr_p1_d  = in_real;
            xi_p1_d  = in_imag;
            wr_p1_d  = tw_real;
            wi_p1_d  = wi_eff;
            // S2: pre-adds
            vld_p2_d = vld_p1_q;
            byp_p2_d = byp_p1_q;
            xr_p2_d  = xr_p1_q;
            xi_p2_d  = xi_p1_q;
            wr_p2_d  = wr_p1_q;
            p0_p2_d  = (DATA_W+1)'(xr_p1_q) + (DATA_W+1)'(xi_p1_q);
            p1_p2_d  = (TW_W+2)'(wi_p1_q) - (TW_W+2)'(wr_p1_q);
            p2_p2_d  = (TW_W+2)'(wr_p1_q) + (TW_W+2)'(wi_p1_q);
            // S3: full-precision products
            vld_p3_d = vld_p2_q;
            byp_p3_d = byp_p2_q;
            xr_p3_d  = xr_p2_q;
            xi_p3_d  = xi_p2_q;
            m0_p3_d  = MW0'(wr_p2_q) * MW0'(p0_p2_q);
            m1_p3_d  = MW1'(xr_p2_q) * MW1'(p1_p2_q);
            m2_p3_d  = MW1'(xi_p2_q) * MW1'(p2_p2_q);
            // S4: post-add, round, saturate into the output register
            out_valid_d = vld_p3_q;
            out_real_d  = byp_p3_q ? xr_p3_q : re_res;
            out_imag_d  = byp_p3_q ? xi_p3_q : im_res;
            if (vld_p3_q && !byp_p3_q && (re_ovf || im_ovf)) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        xr_p1_q <= xr_p1_d; xi_p1_q <= xi_p1_d; wr_p1_q <= wr_p1_d; wi_p1_q <= wi_p1_d;
        byp_p1_q <= byp_p1_d;
        xr_p2_q <= xr_p2_d; xi_p2_q <= xi_p2_d; wr_p2_q <= wr_p2_d;
        p0_p2_q <= p0_p2_d; p1_p2_q <= p1_p2_d; p2_p2_q <= p2_p2_d;
        byp_p2_q <= byp_p2_d;
        xr_p3_q <= xr_p3_d; xi_p3_q <= xi_p3_d;
        m0_p3_q <= m0_p3_d; m1_p3_q <= m1_p3_d; m2_p3_q <= m2_p3_d;
        byp_p3_q <= byp_p3_d;
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            vld_p3_q    <= vld_p3_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_twiddle_cmult_pipe.sv
// Directed bench for twiddle_cmult_pipe at DATA_W=TW_W=16, with a saturating and a
// wrapping instance sharing the same stimulus.
module tb_twiddle_cmult_pipe;

    logic clk = 1'b0;
    logic rst, in_valid, conj, bypass, out_ready, sat_clear;
    logic signed [15:0] in_real, in_imag, tw_real, tw_imag;
    logic in_ready, out_valid, sat_flag;
    logic signed [15:0] out_real, out_imag;
    logic w_in_ready, w_out_valid, w_sat_flag;
    logic signed [15:0] w_out_real, w_out_imag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    twiddle_cmult_pipe #(.DATA_W(16), .TW_W(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .tw_real(tw_real), .tw_imag(tw_imag),
        .conj(conj), .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .sat_flag(sat_flag), .sat_clear(sat_clear)
    );

    twiddle_cmult_pipe #(.DATA_W(16), .TW_W(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_real(in_real), .in_imag(in_imag), .tw_real(tw_real), .tw_imag(tw_imag),
        .conj(conj), .bypass(bypass), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_real(w_out_real), .out_imag(w_out_imag), .sat_flag(w_sat_flag), .sat_clear(sat_clear)
    );

    task automatic drive(input int xr, input int xi, input int wr, input int wi,
                         input logic cj, input logic bp);
        in_valid = 1'b1;
        in_real  = 16'(xr);
        in_imag  = 16'(xi);
        tw_real  = 16'(wr);
        tw_imag  = 16'(wi);
        conj     = cj;
        bypass   = bp;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        conj     = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; sat_clear = 1'b0; idle();
        in_real = '0; in_imag = '0; tw_real = '0; tw_imag = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_real !== 16'sd0 || out_imag !== 16'sd0 || sat_flag !== 1'b0)
            begin errors++; $display("FAIL reset_state: got v=%b re=%0d im=%0d sat=%b, want 0 0 0 0",
                out_valid, out_real, out_imag, sat_flag); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (w_out_valid !== 1'b0 || w_sat_flag !== 1'b0)
            begin errors++; $display("FAIL reset_wrap: got v=%b sat=%b want 0 0", w_out_valid, w_sat_flag); end
    endtask

    task automatic test_identity();
        @(negedge clk); drive(1000, -2000, 32767, 0, 1'b0, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL identity_latency_early: out_valid=%b want 0", out_valid); end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_real !== 16'sd1000 || out_imag !== -16'sd2000)
            begin errors++; $display("FAIL identity: got v=%b (%0d,%0d) want 1 (1000,-2000)",
                out_valid, out_real, out_imag); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL identity_sat: got %b want 0", sat_flag); end
    endtask

    task automatic test_rotation();
        int er[2] = '{-2000, 2000};
        int ei[2] = '{-1000, 1000};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0)      drive(1000, -2000, 0, -32768, 1'b0, 1'b0);
            else if (c == 1) drive(1000, -2000, 0, -32768, 1'b1, 1'b0);
            else             idle();
            #1;
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rotation_latency: out_valid=%b want 0", out_valid); end
            end
            if (c >= 4 && c < 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_real !== 16'(er[c-4]) || out_imag !== 16'(ei[c-4]))
                    begin errors++; $display("FAIL rotation[%0d]: got v=%b (%0d,%0d) want 1 (%0d,%0d)",
                        c-4, out_valid, out_real, out_imag, er[c-4], ei[c-4]); end
            end
        end
    endtask

    task automatic test_bypass_mix();
        int er[5] = '{100, -50, 100, -50, -32768};
        int ei[5] = '{50, 100, 50, 100, -32768};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 4)       drive(100, 50, 0, 32767, 1'b0, (c % 2) == 0);
            else if (c == 4) drive(-32768, -32768, -32768, 0, 1'b0, 1'b1);
            else             idle();
            #1;
            if (c >= 4 && c < 9) begin
                checks++;
                if (out_valid !== 1'b1 || out_real !== 16'(er[c-4]) || out_imag !== 16'(ei[c-4]))
                    begin errors++; $display("FAIL bypass_mix[%0d]: got v=%b (%0d,%0d) want 1 (%0d,%0d)",
                        c-4, out_valid, out_real, out_imag, er[c-4], ei[c-4]); end
            end
        end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL bypass_no_sat: got %b want 0", sat_flag); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int oidx = 0;
        logic signed [15:0] hr, hi;
        hr = '0; hi = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c < 11);
            if (idx < 8) drive(100 * (idx + 1), -(50 * idx + 3), 32767, 0, 1'b0, 1'b0);
            else         idle();
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready); end
                if (c == 5) begin
                    hr = out_real; hi = out_imag;
                end else begin
                    checks++;
                    if (out_valid !== 1'b1 || out_real !== hr || out_imag !== hi)
                        begin errors++; $display("FAIL stall_hold c=%0d: got v=%b (%0d,%0d) want 1 (%0d,%0d)",
                            c, out_valid, out_real, out_imag, hr, hi); end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (oidx >= 8) begin
                    errors++; $display("FAIL stream_extra: got (%0d,%0d) want no output", out_real, out_imag);
                end else if (out_real !== 16'(100 * (oidx + 1)) || out_imag !== 16'(-(50 * oidx + 3))) begin
                    errors++; $display("FAIL stream[%0d]: got (%0d,%0d) want (%0d,%0d)",
                        oidx, out_real, out_imag, 100 * (oidx + 1), -(50 * oidx + 3));
                end
                oidx++;
            end
            if (in_valid && in_ready) idx++;
        end
        out_ready = 1'b1;
        checks++;
        if (oidx != 8 || idx != 8) begin errors++; $display("FAIL stream_count: got out=%0d in=%0d want 8 8", oidx, idx); end
    endtask

    task automatic test_saturation();
        @(negedge clk); drive(-32768, -32768, -32768, 0, 1'b0, 1'b0);
        repeat (4) begin @(negedge clk); idle(); end
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_real !== 16'sd32767 || out_imag !== 16'sd32767 || sat_flag !== 1'b1)
            begin errors++; $display("FAIL sat_clamp: got v=%b (%0d,%0d) flag=%b want 1 (32767,32767) 1",
                out_valid, out_real, out_imag, sat_flag); end
        checks++;
        if (w_out_real !== -16'sd32768 || w_out_imag !== -16'sd32768 || w_sat_flag !== 1'b1)
            begin errors++; $display("FAIL sat_wrap: got (%0d,%0d) flag=%b want (-32768,-32768) 1",
                w_out_real, w_out_imag, w_sat_flag); end
        @(negedge clk); sat_clear = 1'b1;
        @(negedge clk); sat_clear = 1'b0;
        #1;
        checks++;
        if (sat_flag !== 1'b0 || w_sat_flag !== 1'b0)
            begin errors++; $display("FAIL sat_clear: got %b %b want 0 0", sat_flag, w_sat_flag); end
        @(negedge clk); drive(-32768, -32768, -32768, 0, 1'b0, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); sat_clear = 1'b1;
        @(negedge clk); sat_clear = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || sat_flag !== 1'b1 || w_sat_flag !== 1'b1)
            begin errors++; $display("FAIL sat_set_wins: got v=%b flags %b %b want 1 1 1",
                out_valid, sat_flag, w_sat_flag); end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); drive(1111 * (c + 1), 2222, 32767, 0, 1'b0, 1'b0);
        end
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_real !== 16'sd0 || out_imag !== 16'sd0 || sat_flag !== 1'b0)
            begin errors++; $display("FAIL midreset_state: got v=%b (%0d,%0d) sat=%b want 0 (0,0) 0",
                out_valid, out_real, out_imag, sat_flag); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_flush: got %0d outputs want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rotation();
        test_bypass_mix();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
